// File: rtl/l15_arb_pkg.sv
// l15_arb_pkg: shared types and constants for the L1.5 request arbiter.
// Holds the FSM state enum, response returntype encodings and the list of
// returntypes that arrive unsolicited (not tied to an outstanding request).

`ifndef L15_THREADID_WIDTH
`define L15_THREADID_WIDTH 2
`endif

package l15_arb_pkg;

  localparam int TID_W = `L15_THREADID_WIDTH;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Response returntype encodings
  localparam logic [3:0] RT_LOAD   = 4'h0;
  localparam logic [3:0] RT_IFILL  = 4'h1;
  localparam logic [3:0] RT_EVICT  = 4'h3;
  localparam logic [3:0] RT_ST_ACK = 4'h4;
  localparam logic [3:0] RT_INT    = 4'h7;

  // Returntypes that are pushed by the L1.5 without a matching request
  localparam int N_UNSOL = 2;
  localparam logic [3:0] UNSOL_LIST [N_UNSOL] = '{RT_EVICT, RT_INT};

  function automatic logic is_unsolicited(input logic [3:0] rt);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_UNSOL; i++) begin
      hit = hit | (rt == UNSOL_LIST[i]);
    end
    return hit;
  endfunction

endpackage

// File: rtl/l15_arb_outst_cnt.sv
// l15_arb_outst_cnt: per-requester in-flight request counter.
// Counts up on grant, down on a consumed solicited response, never wraps
// below zero; flags full (mask requester) and underflow (stray response).

module l15_arb_outst_cnt
  import l15_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,        // request granted this cycle
  input  logic rsp_i,        // solicited response aimed at this requester
  input  logic ack_i,        // that response is being consumed
  output logic full_o,
  output logic underflow_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             zero_s;
  logic             dec_s;

  assign zero_s      = (cnt_q == CNT_ZERO);
  assign dec_s       = ack_i && !zero_s;
  assign full_o      = (cnt_q >= MAX_C);
  assign underflow_o = rsp_i && zero_s;

  // Next count: simultaneous increment and decrement cancel out
  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/l15_req_arb.sv
// l15_req_arb: arbitrates two requesters (0 = I-side, 1 = D-side) onto a
// single L1.5 request port and routes L1.5 responses back to them.
// Build option: define L15_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed priority with requester 1 ahead of requester 0.

module l15_req_arb
  import l15_arb_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0_val,
  output logic                           req0_rdy,
  input  logic [4:0]                     req0_rqtype,
  input  logic                           req0_nc,
  input  logic [2:0]                     req0_size,
  input  logic [39:0]                    req0_address,
  input  logic [63:0]                    req0_data,
  input  logic                           req1_val,
  output logic                           req1_rdy,
  input  logic [4:0]                     req1_rqtype,
  input  logic                           req1_nc,
  input  logic [2:0]                     req1_size,
  input  logic [39:0]                    req1_address,
  input  logic [63:0]                    req1_data,
  output logic                           transducer_l15_val,
  output logic [4:0]                     transducer_l15_rqtype,
  output logic                           transducer_l15_nc,
  output logic [2:0]                     transducer_l15_size,
  output logic [39:0]                    transducer_l15_address,
  output logic [63:0]                    transducer_l15_data,
  output logic [`L15_THREADID_WIDTH-1:0] transducer_l15_threadid,
  input  logic                           l15_transducer_ack,
  input  logic                           l15_transducer_val,
  input  logic [3:0]                     l15_transducer_returntype,
  input  logic [`L15_THREADID_WIDTH-1:0] l15_transducer_threadid,
  input  logic [63:0]                    l15_transducer_data,
  output logic                           transducer_l15_req_ack,
  output logic                           rsp0_val,
  input  logic                           rsp0_rdy,
  output logic [3:0]                     rsp0_returntype,
  output logic [63:0]                    rsp0_data,
  output logic                           rsp1_val,
  input  logic                           rsp1_rdy,
  output logic [3:0]                     rsp1_returntype,
  output logic [63:0]                    rsp1_data,
  output logic                           err_sticky
);

  arb_state_e        state_q, state_d;
  logic              val_q, val_d;
  logic [4:0]        rqtype_q, rqtype_d;
  logic              nc_q, nc_d;
  logic [2:0]        size_q, size_d;
  logic [39:0]       addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic [TID_W-1:0]  tid_q, tid_d;
  logic              err_q, err_d;
  logic              rst_dly_q;
`ifdef L15_ARB_RR_EN
  logic              ptr_q, ptr_d;
`endif

  logic blk_s;
  logic full0_s, full1_s, uf0_s, uf1_s;
  logic elig0_s, elig1_s, gnt0_s, gnt1_s, gnt_any_s;
  logic rsp_live_s, unsol_s, sol0_s, sol1_s, unsol1_s, hs0_s, hs1_s;
  logic tid_unused_s;

  // Outputs are forced quiet during reset and the cycle that follows it
  assign blk_s = rst | rst_dly_q;

  assign elig0_s   = req0_val && !full0_s;
  assign elig1_s   = req1_val && !full1_s;
  assign gnt_any_s = gnt0_s | gnt1_s;

  // Grant selection, only while idle and not blocked by reset
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == ST_IDLE && !blk_s) begin
`ifdef L15_ARB_RR_EN
      if (elig0_s && elig1_s) begin
        gnt0_s = !ptr_q;
        gnt1_s = ptr_q;
      end else begin
        gnt0_s = elig0_s;
        gnt1_s = elig1_s;
      end
`else
      gnt1_s = elig1_s;
      gnt0_s = elig0_s && !elig1_s;
`endif
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state and request-register capture for the issue FSM
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    rqtype_d = rqtype_q;
    nc_d     = nc_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tid_d    = tid_q;
    if (gnt_any_s) begin
      state_d  = ST_ISSUE;
      val_d    = 1'b1;
      rqtype_d = gnt1_s ? req1_rqtype  : req0_rqtype;
      nc_d     = gnt1_s ? req1_nc      : req0_nc;
      size_d   = gnt1_s ? req1_size    : req0_size;
      addr_d   = gnt1_s ? req1_address : req0_address;
      data_d   = gnt1_s ? req1_data    : req0_data;
      tid_d    = TID_W'(gnt1_s);
    end else if (state_q == ST_ISSUE && val_q && l15_transducer_ack) begin
      state_d = ST_IDLE;
      val_d   = 1'b0;
    end else begin
      state_d = state_q;
      val_d   = val_q;
    end
  end

`ifdef L15_ARB_RR_EN
  // Round-robin pointer moves to the requester that lost this grant
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_s) begin
      ptr_d = !gnt1_s;
    end else begin
      ptr_d = ptr_q;
    end
  end
`endif

  // Response routing: unsolicited types always go to requester 1
  assign unsol_s    = is_unsolicited(l15_transducer_returntype);
  assign rsp_live_s = l15_transducer_val && !blk_s;
  assign sol0_s     = rsp_live_s && !unsol_s && !l15_transducer_threadid[0];
  assign sol1_s     = rsp_live_s && !unsol_s &&  l15_transducer_threadid[0];
  assign unsol1_s   = rsp_live_s && unsol_s;

  assign rsp0_val = sol0_s && !uf0_s;
  assign rsp1_val = (sol1_s && !uf1_s) || unsol1_s;
  assign hs0_s    = rsp0_val && rsp0_rdy;
  assign hs1_s    = rsp1_val && rsp1_rdy;

  // A stray solicited response is consumed (dropped) without a requester
  assign transducer_l15_req_ack = hs0_s | hs1_s | uf0_s | uf1_s;
  assign err_d = err_q | uf0_s | uf1_s;

  assign rsp0_returntype = rsp0_val ? l15_transducer_returntype : 4'd0;
  assign rsp0_data       = rsp0_val ? l15_transducer_data       : 64'd0;
  assign rsp1_returntype = rsp1_val ? l15_transducer_returntype : 4'd0;
  assign rsp1_data       = rsp1_val ? l15_transducer_data       : 64'd0;

  assign tid_unused_s = ^l15_transducer_threadid;

  l15_arb_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst0 (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (gnt0_s),
    .rsp_i       (sol0_s),
    .ack_i       (hs0_s),
    .full_o      (full0_s),
    .underflow_o (uf0_s)
  );

  l15_arb_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst1 (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (gnt1_s),
    .rsp_i       (sol1_s),
    .ack_i       (hs1_s && sol1_s),
    .full_o      (full1_s),
    .underflow_o (uf1_s)
  );

  // FSM state, captured request, error flag and reset-delay register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      val_q     <= 1'b0;
      rqtype_q  <= 5'd0;
      nc_q      <= 1'b0;
      size_q    <= 3'd0;
      addr_q    <= 40'd0;
      data_q    <= 64'd0;
      tid_q     <= '0;
      err_q     <= 1'b0;
      rst_dly_q <= 1'b1;
`ifdef L15_ARB_RR_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      rqtype_q  <= rqtype_d;
      nc_q      <= nc_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tid_q     <= tid_d;
      err_q     <= err_d;
      rst_dly_q <= 1'b0;
`ifdef L15_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign req0_rdy                = gnt0_s;
  assign req1_rdy                = gnt1_s;
  assign transducer_l15_val      = blk_s ? 1'b0  : val_q;
  assign transducer_l15_rqtype   = blk_s ? 5'd0  : rqtype_q;
  assign transducer_l15_nc       = blk_s ? 1'b0  : nc_q;
  assign transducer_l15_size     = blk_s ? 3'd0  : size_q;
  assign transducer_l15_address  = blk_s ? 40'd0 : addr_q;
  assign transducer_l15_data     = blk_s ? 64'd0 : data_q;
  assign transducer_l15_threadid = blk_s ? '0    : tid_q;
  assign err_sticky              = blk_s ? 1'b0  : err_q;

endmodule

// File: tb/tb_l15_req_arb.sv
// tb_l15_req_arb: directed, table-driven bench for l15_req_arb (MAX_OUTST=2).
// Works with or without L15_ARB_RR_EN; the first winner depends on the build.

module tb_l15_req_arb;
  import l15_arb_pkg::*;

`ifdef L15_ARB_RR_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif
  localparam int SECOND = 1 - FIRST;

  localparam logic [39:0] ADDR0 = 40'h11_2233_4450;
  localparam logic [39:0] ADDR1 = 40'h99_8877_6650;
  localparam logic [63:0] DATA0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DATA1 = 64'hFEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst;
  logic req0_val, req0_rdy, req1_val, req1_rdy;
  logic [4:0] req0_rqtype, req1_rqtype;
  logic req0_nc, req1_nc;
  logic [2:0] req0_size, req1_size;
  logic [39:0] req0_address, req1_address;
  logic [63:0] req0_data, req1_data;
  logic t_val, t_nc;
  logic [4:0] t_rqtype;
  logic [2:0] t_size;
  logic [39:0] t_addr;
  logic [63:0] t_data;
  logic [TID_W-1:0] t_tid;
  logic l15_ack, l15_val;
  logic [3:0] l15_rt;
  logic [TID_W-1:0] l15_tid;
  logic [63:0] l15_data;
  logic req_ack;
  logic rsp0_val, rsp0_rdy, rsp1_val, rsp1_rdy;
  logic [3:0] rsp0_rt, rsp1_rt;
  logic [63:0] rsp0_data, rsp1_data;
  logic err_sticky;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic             val;
    logic [3:0]       rt;
    logic [TID_W-1:0] tid;
    logic             r0rdy;
    logic             r1rdy;
    logic             e0;
    logic             e1;
    logic             eack;
  } rvec_t;

  rvec_t vecs [7];

  l15_req_arb #(.MAX_OUTST(2)) dut (
    .clk(clk), .rst(rst),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_rqtype(req0_rqtype),
    .req0_nc(req0_nc), .req0_size(req0_size), .req0_address(req0_address),
    .req0_data(req0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_rqtype(req1_rqtype),
    .req1_nc(req1_nc), .req1_size(req1_size), .req1_address(req1_address),
    .req1_data(req1_data),
    .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rqtype),
    .transducer_l15_nc(t_nc), .transducer_l15_size(t_size),
    .transducer_l15_address(t_addr), .transducer_l15_data(t_data),
    .transducer_l15_threadid(t_tid),
    .l15_transducer_ack(l15_ack), .l15_transducer_val(l15_val),
    .l15_transducer_returntype(l15_rt), .l15_transducer_threadid(l15_tid),
    .l15_transducer_data(l15_data),
    .transducer_l15_req_ack(req_ack),
    .rsp0_val(rsp0_val), .rsp0_rdy(rsp0_rdy), .rsp0_returntype(rsp0_rt),
    .rsp0_data(rsp0_data),
    .rsp1_val(rsp1_val), .rsp1_rdy(rsp1_rdy), .rsp1_returntype(rsp1_rt),
    .rsp1_data(rsp1_data),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise req0, wait (bounded) for its grant, then accept it at the L1.5
  task automatic issue0();
    logic seen;
    seen = 1'b0;
    req0_val = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #2;
      if (req0_rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("issue0_grant", {63'd0, seen}, 64'd1);
    step();
    req0_val = 1'b0;
    #2;
    chk("issue0_val", {63'd0, t_val}, 64'd1);
    chk("issue0_tid", 64'(t_tid), 64'd0);
    l15_ack = 1'b1;
    step();
    l15_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, RT_LOAD,   TID_W'(0), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, RT_LOAD,   TID_W'(0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, RT_IFILL,  TID_W'(1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, RT_ST_ACK, TID_W'(2), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, RT_EVICT,  TID_W'(0), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, RT_INT,    TID_W'(1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, RT_INT,    TID_W'(0), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    req0_val = 1'b1; req0_rqtype = 5'd2; req0_nc = 1'b0; req0_size = 3'd3;
    req0_address = ADDR0; req0_data = DATA0;
    req1_val = 1'b1; req1_rqtype = 5'd9; req1_nc = 1'b1; req1_size = 3'd1;
    req1_address = ADDR1; req1_data = DATA1;
    l15_ack = 1'b0; l15_val = 1'b1; l15_rt = RT_LOAD; l15_tid = TID_W'(0);
    l15_data = 64'hA5A5_0000_5A5A_FFFF; rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;

    // Reset: everything quiet even with live inputs
    repeat (2) step();
    #2;
    chk("rst_req0_rdy", {63'd0, req0_rdy}, 64'd0);
    chk("rst_req1_rdy", {63'd0, req1_rdy}, 64'd0);
    chk("rst_t_val", {63'd0, t_val}, 64'd0);
    chk("rst_rsp0_val", {63'd0, rsp0_val}, 64'd0);
    chk("rst_req_ack", {63'd0, req_ack}, 64'd0);
    chk("rst_err", {63'd0, err_sticky}, 64'd0);
    step();
    rst = 1'b0; l15_val = 1'b0; rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    #2;
    chk("postrst_req0_rdy", {63'd0, req0_rdy}, 64'd0);
    chk("postrst_req1_rdy", {63'd0, req1_rdy}, 64'd0);

    // Both requesting from IDLE: first winner depends on arbitration mode
    step();
    #2;
    chk("gnt1_first_rdy", {63'd0, (FIRST == 1) ? req1_rdy : req0_rdy}, 64'd1);
    chk("gnt1_other_rdy", {63'd0, (FIRST == 1) ? req0_rdy : req1_rdy}, 64'd0);
    step();
    if (FIRST == 1) req1_val = 1'b0; else req0_val = 1'b0;

    // Ack held low 5 cycles: request held stable, no second grant
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("hold_val", {63'd0, t_val}, 64'd1);
      chk("hold_addr", {24'd0, t_addr}, {24'd0, (FIRST == 1) ? ADDR1 : ADDR0});
      chk("hold_no_gnt", {62'd0, req1_rdy, req0_rdy}, 64'd0);
      step();
    end
    chk("issue_tid", 64'(t_tid), 64'(FIRST));
    chk("issue_data", t_data, (FIRST == 1) ? DATA1 : DATA0);
    chk("issue_rqtype", 64'(t_rqtype), (FIRST == 1) ? 64'd9 : 64'd2);
    l15_ack = 1'b1;
    #2;
    chk("ack_cycle_val", {63'd0, t_val}, 64'd1);
    step();
    l15_ack = 1'b0;
    #2;
    chk("after_ack_val", {63'd0, t_val}, 64'd0);
    chk("second_gnt", {63'd0, (SECOND == 1) ? req1_rdy : req0_rdy}, 64'd1);
    step();
    if (SECOND == 1) req1_val = 1'b0; else req0_val = 1'b0;
    #2;
    chk("second_val", {63'd0, t_val}, 64'd1);
    chk("second_tid", 64'(t_tid), 64'(SECOND));
    chk("second_addr", {24'd0, t_addr}, {24'd0, (SECOND == 1) ? ADDR1 : ADDR0});
    l15_ack = 1'b1;
    step();
    l15_ack = 1'b0;
    #2;
    chk("idle_val", {63'd0, t_val}, 64'd0);

    // Response routing table (one outstanding per requester, no decrements)
    for (int i = 0; i < 7; i++) begin
      l15_val = vecs[i].val; l15_rt = vecs[i].rt; l15_tid = vecs[i].tid;
      rsp0_rdy = vecs[i].r0rdy; rsp1_rdy = vecs[i].r1rdy;
      #2;
      chk($sformatf("vec%0d_rsp0_val", i), {63'd0, rsp0_val}, {63'd0, vecs[i].e0});
      chk($sformatf("vec%0d_rsp1_val", i), {63'd0, rsp1_val}, {63'd0, vecs[i].e1});
      chk($sformatf("vec%0d_req_ack", i), {63'd0, req_ack}, {63'd0, vecs[i].eack});
      step();
    end
    chk("tbl_outst0", 64'(dut.u_outst0.cnt_q), 64'd1);
    chk("tbl_outst1", 64'(dut.u_outst1.cnt_q), 64'd1);
    l15_val = 1'b1; l15_rt = RT_IFILL; l15_tid = TID_W'(0); rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    l15_data = 64'hDEAD_BEEF_0000_1111;
    #2;
    chk("rsp0_data", rsp0_data, 64'hDEAD_BEEF_0000_1111);
    chk("rsp0_rt", 64'(rsp0_rt), 64'(RT_IFILL));

    // Requester 1 response back-pressured for 3 cycles
    l15_tid = TID_W'(1); l15_rt = RT_LOAD;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_req_ack", {63'd0, req_ack}, 64'd0);
      chk("bp_rsp1_val", {63'd0, rsp1_val}, 64'd1);
      chk("bp_outst1", 64'(dut.u_outst1.cnt_q), 64'd1);
      step();
    end
    rsp1_rdy = 1'b1;
    #2;
    chk("bp_release_ack", {63'd0, req_ack}, 64'd1);
    step();
    l15_val = 1'b0; rsp1_rdy = 1'b0;
    #2;
    chk("bp_outst1_dec", 64'(dut.u_outst1.cnt_q), 64'd0);

    // Drain requester 0, then a stray solicited response for it
    l15_val = 1'b1; l15_tid = TID_W'(0); rsp0_rdy = 1'b1;
    #2;
    chk("drain0_ack", {63'd0, req_ack}, 64'd1);
    step();
    rsp0_rdy = 1'b0;
    #2;
    chk("drain0_outst0", 64'(dut.u_outst0.cnt_q), 64'd0);
    chk("stray_ack", {63'd0, req_ack}, 64'd1);
    chk("stray_rsp0_val", {63'd0, rsp0_val}, 64'd0);
    chk("stray_err_pre", {63'd0, err_sticky}, 64'd0);
    step();
    l15_val = 1'b0;
    #2;
    chk("stray_err", {63'd0, err_sticky}, 64'd1);
    chk("stray_outst0", 64'(dut.u_outst0.cnt_q), 64'd0);
    step();

    // Requester 0 saturates at MAX_OUTST=2; requester 1 still wins
    issue0();
    issue0();
    chk("full_outst0", 64'(dut.u_outst0.cnt_q), 64'd2);
    req0_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("full_req0_rdy", {63'd0, req0_rdy}, 64'd0);
      chk("full_t_val", {63'd0, t_val}, 64'd0);
      step();
    end
    req1_val = 1'b1;
    #2;
    chk("full_req1_rdy", {63'd0, req1_rdy}, 64'd1);
    chk("full_req0_rdy2", {63'd0, req0_rdy}, 64'd0);
    step();
    req0_val = 1'b0; req1_val = 1'b0;
    #2;
    chk("full_issue_val", {63'd0, t_val}, 64'd1);
    chk("full_issue_tid", 64'(t_tid), 64'd1);

    // Reset in the middle of ISSUE drops the request and clears counters
    rst = 1'b1;
    #2;
    chk("midrst_val", {63'd0, t_val}, 64'd0);
    step();
    rst = 1'b0;
    #2;
    chk("midrst_val_next", {63'd0, t_val}, 64'd0);
    chk("midrst_outst0", 64'(dut.u_outst0.cnt_q), 64'd0);
    chk("midrst_outst1", 64'(dut.u_outst1.cnt_q), 64'd0);
    chk("midrst_err", {63'd0, err_sticky}, 64'd0);
    step();
    #2;
    chk("midrst_idle_val", {63'd0, t_val}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l15_req_arb.md
L15_REQ_ARB -- requirements
Module: l15_req_arb

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4: maximum in-flight requests per requester (range 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports reqN_val/reqN_rdy (N=0,1), input/output, 1 each: per-requester request handshake (0 = I-side, 1 = D-side).
REQ-005 SHALL have ports reqN_rqtype, reqN_nc, reqN_size, reqN_address, reqN_data, input, 5/1/3/40/64: request fields.
REQ-006 SHALL have ports transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc, transducer_l15_size, transducer_l15_address, transducer_l15_data, transducer_l15_threadid, output, 1/5/1/3/40/64/`L15_THREADID_WIDTH: shared L1.5 request port.
REQ-007 SHALL have port l15_transducer_ack, input, 1: L1.5 request accept.
REQ-008 SHALL have ports l15_transducer_val, l15_transducer_returntype, l15_transducer_threadid, l15_transducer_data[63:0], input: L1.5 response.
REQ-009 SHALL have port transducer_l15_req_ack, output, 1: response consumed.
REQ-010 SHALL have ports rspN_val/rspN_rdy, output/input, 1 each, plus rspN_returntype (4) and rspN_data (64), output: per-requester response.

Function
REQ-011 SHALL run FSM IDLE -> ISSUE (grant captured into request register) -> IDLE on transducer_l15_val && l15_transducer_ack.
REQ-012 SHALL, in IDLE, grant one eligible requester; eligible = reqN_val && outstN < MAX_OUTST.
REQ-013 SHALL assert reqN_rdy for exactly the granted requester in the grant cycle; request fields captured that edge.
REQ-014 SHALL assert transducer_l15_val the cycle after grant and hold it with stable fields until l15_transducer_ack; no back-to-back issue (ISSUE->IDLE->ISSUE, 2-cycle minimum).
REQ-015 SHALL drive transducer_l15_threadid = granted index, zero-extended.
REQ-016 SHALL increment outstN on grant; decrement on rspN_val && rspN_rdy for a solicited response; same-cycle increment and decrement leave outstN unchanged.
REQ-017 SHALL route solicited responses to rsp[l15_transducer_threadid[0]]; returntypes in the package UNSOLICITED list route to rsp1 without decrement.
REQ-018 SHALL pass response combinationally: rspN_val = l15_transducer_val && routed-to-N; transducer_l15_req_ack = rspN_val && rspN_rdy.
REQ-019 SHALL never decrement below 0; a solicited response with outstN = 0 is dropped (req_ack asserted) and flags err_sticky (output, 1), cleared only by rst.
REQ-020 SHALL mask requester N while outstN = MAX_OUTST; the other requester may still win.

Reset
REQ-021 SHALL, on rst, go to IDLE, clear outst0/outst1, clear err_sticky, and set the RR pointer to 0.
REQ-022 SHALL drive all outputs 0 during rst and the cycle after; rst mid-ISSUE drops the captured request.

Configuration
REQ-023 SHALL, with L15_ARB_RR_EN defined, arbitrate round-robin: pointer toggles to the non-granted requester after each grant.
REQ-024 SHALL, without L15_ARB_RR_EN, use fixed priority with req1 over req0; no pointer register.

Structure
REQ-025 SHALL place the FSM state enum, returntype constants, and UNSOLICITED list in package l15_arb_pkg.
REQ-026 SHALL instantiate one sub-module, l15_arb_outst_cnt, per requester (counter, full flag, underflow flag).

Verification
REQ-027 SHALL cover: both reqN_val=1 from IDLE, RR build -> req0 granted first, req1 granted 2 cycles after req0's ack.
REQ-028 SHALL cover: ack held low 5 cycles -> transducer_l15_val and address stay stable 5 cycles; no second grant.
REQ-029 SHALL cover: MAX_OUTST=2, req0 issues 2 with no responses -> req0_rdy stays 0 and req1 is still granted.
REQ-030 SHALL cover: response threadid=1 with rsp1_rdy=0 for 3 cycles -> transducer_l15_req_ack stays 0 until rsp1_rdy=1, then outst1 decrements.
REQ-031 SHALL cover: solicited response with outst0=0 -> req_ack=1 and err_sticky=1 next cycle.
REQ-032 SHALL cover: rst asserted mid-ISSUE -> transducer_l15_val=0 the next cycle and counters are 0.
